avaliador_jogada: RTL

AVALIADOR_JOGADA -- requirements
Module: avaliador_jogada

---
 rtl/jogo_pkg.sv | 31 +++
 rtl/avaliador_jogada_if.sv | 24 ++
 rtl/detector_borda.sv | 28 ++
 rtl/avaliador_jogada.sv | 112 +++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// Shared types and defaults for the note-evaluation game logic.
// Holds the FSM encoding, default window timing and the window computation.
package jogo_pkg;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        JANELA    = 2'd1,
        RESULTADO = 2'd2
    } estado_t;

    localparam int unsigned JANELA_BASE_PADRAO = 1000;
    localparam int unsigned REDUCAO_PADRAO     = 100;
    localparam int unsigned JANELA_MIN_PADRAO  = 200;
    localparam int unsigned NUM_BOTOES         = 4;

    // A reduction larger than the base would wrap, so it clamps like any short window.
    function automatic logic [15:0] calc_janela(input int unsigned base,
                                                input int unsigned reducao,
                                                input int unsigned minimo,
                                                input logic [2:0]  linhas);
        logic [19:0] produto;
        logic [19:0] resto;
        produto = 20'(reducao) * 20'(linhas);
        resto   = 20'(base) - produto;
        if (produto > 20'(base) || resto < 20'(minimo)) begin
            return 16'(minimo);
        end
        return resto[15:0];
    endfunction

endpackage

// File: rtl/avaliador_jogada_if.sv
// Round-control and result bundle between the game controller and the evaluator.
interface avaliador_jogada_if;
    import jogo_pkg::*;

    logic                  iniciar;
    logic [NUM_BOTOES-1:0] nota_alvo;
    logic [NUM_BOTOES-1:0] botoes;
    logic [2:0]            linhas_bloq;
    logic                  acertou;
    logic                  errou;
    logic                  pronto;
    logic [15:0]           tempo_resposta;

    modport master (
        output iniciar, nota_alvo, botoes, linhas_bloq,
        input  acertou, errou, pronto, tempo_resposta
    );

    modport slave (
        input  iniciar, nota_alvo, botoes, linhas_bloq,
        output acertou, errou, pronto, tempo_resposta
    );

endinterface

// File: rtl/detector_borda.sv
// Registers a synchronous level bus and flags bits that rose since the previous cycle.
module detector_borda #(
    parameter int unsigned LARGURA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] entrada,
    output logic [LARGURA-1:0] borda
);

    logic [LARGURA-1:0] entrada_q;
    logic [LARGURA-1:0] entrada_d;

    always_comb begin
        entrada_d = entrada;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            entrada_q <= '0;
        end else begin
            entrada_q <= entrada_d;
        end
    end

    assign borda = entrada & ~entrada_q;

endmodule

// File: rtl/avaliador_jogada.sv
// Evaluates one player press against a one-hot target note inside a shrinking response window.
// Emits a single-cycle hit or miss pulse and the measured response time.
module avaliador_jogada
    import jogo_pkg::*;
#(
    parameter int unsigned JANELA_BASE = JANELA_BASE_PADRAO,
    parameter int unsigned REDUCAO     = REDUCAO_PADRAO,
    parameter int unsigned JANELA_MIN  = JANELA_MIN_PADRAO
) (
    input logic               clock,
    input logic               reset,
    avaliador_jogada_if.slave bus
);

    estado_t               estado_q,   estado_d;
    logic [NUM_BOTOES-1:0] nota_q,     nota_d;
    logic [15:0]           contador_q, contador_d;
    logic [15:0]           tempo_q,    tempo_d;
    logic                  acertou_q,  acertou_d;
    logic                  errou_q,    errou_d;
    logic                  pronto_q,   pronto_d;

    logic [NUM_BOTOES-1:0] borda;
    logic [15:0]           janela;

    detector_borda #(
        .LARGURA (NUM_BOTOES)
    ) u_detector_borda (
        .clock   (clock),
        .reset   (reset),
        .entrada (bus.botoes),
        .borda   (borda)
    );

    assign janela = calc_janela(JANELA_BASE, REDUCAO, JANELA_MIN, bus.linhas_bloq);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        estado_d   = estado_q;
        nota_d     = nota_q;
        contador_d = contador_q;
        tempo_d    = tempo_q;
        acertou_d  = 1'b0;
        errou_d    = 1'b0;

        case (estado_q)
            OCIOSO: begin
                if (bus.iniciar && $onehot(bus.nota_alvo)) begin
                    nota_d     = bus.nota_alvo;
                    contador_d = janela;
                    tempo_d    = '0;
                    estado_d   = JANELA;
                end
            end

            JANELA: begin
                // Any press ends the round, even on the last window cycle.
                if (borda != '0) begin
                    acertou_d = (borda == nota_q);
                    errou_d   = (borda != nota_q);
                    estado_d  = RESULTADO;
                end else begin
                    if (tempo_q != 16'hFFFF) begin
                        tempo_d = tempo_q + 16'd1;
                    end
                    contador_d = contador_q - 16'd1;
                    if (contador_q <= 16'd1) begin
                        errou_d  = 1'b1;
                        estado_d = RESULTADO;
                    end
                end
            end

            RESULTADO: begin
                estado_d = OCIOSO;
            end

            default: begin
                estado_d = OCIOSO;
            end
        endcase

        pronto_d = (estado_d == OCIOSO);
    end

    // NOTE: state is updated with <= so every flop samples the same pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            nota_q     <= '0;
            contador_q <= '0;
            tempo_q    <= '0;
            acertou_q  <= 1'b0;
            errou_q    <= 1'b0;
            pronto_q   <= 1'b1;
        end else begin
            estado_q   <= estado_d;
            nota_q     <= nota_d;
            contador_q <= contador_d;
            tempo_q    <= tempo_d;
            acertou_q  <= acertou_d;
            errou_q    <= errou_d;
            pronto_q   <= pronto_d;
        end
    end

    assign bus.acertou        = acertou_q;
    assign bus.errou          = errou_q;
    assign bus.pronto         = pronto_q;
    assign bus.tempo_resposta = tempo_q;

endmodule
